// File: rtl/jpeg_rle_pkg.sv
// Shared constants for the JPEG run-length symbol encoder.
package jpeg_rle_pkg;

  // Symbol kinds carried on out_kind
  localparam logic [1:0] KIND_DC  = 2'd0;
  localparam logic [1:0] KIND_AC  = 2'd1;
  localparam logic [1:0] KIND_ZRL = 2'd2;
  localparam logic [1:0] KIND_EOB = 2'd3;

  // Block geometry and zero-run-length symbol constants
  localparam int unsigned BLOCK_LEN = 64;
  localparam int unsigned ZRL_RUN   = 15;
  localparam int unsigned ZRL_SPAN  = 16;

  // Encoder FSM state encoding
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/rle_size_cat.sv
// Magnitude category of a signed coefficient: number of bits in |value|.
module rle_size_cat #(
  parameter int unsigned COEF_W = 12
) (
  input  logic [COEF_W-1:0] value_i,
  output logic [3:0]        size_o
);

  logic [COEF_W:0] ext;
  logic [COEF_W:0] mag;

  // One extra bit so that |-2^(COEF_W-1)| is representable; size is MSB position + 1
  always_comb begin
    ext    = {value_i[COEF_W-1], value_i};
    mag    = ext[COEF_W] ? (~ext + (COEF_W+1)'(1)) : ext;
    size_o = '0;
    for (int i = 0; i <= int'(COEF_W); i++) begin
      if (mag[i]) size_o = 4'(i + 1);
    end
  end

endmodule

// File: rtl/rle_symbol_encoder.sv
// Zig-zag block run-length encoder: LANES coefficients per beat in, one JPEG
// symbol (DC / AC / ZRL / EOB) per cycle out over valid/ready.
module rle_symbol_encoder
  import jpeg_rle_pkg::*;
#(
  parameter int unsigned COEF_W   = 12,
  parameter int unsigned LANES    = 8,
  parameter int unsigned DC_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*COEF_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_kind,
  output logic [3:0]              out_run,
  output logic [COEF_W-1:0]       out_value,
  output logic [3:0]              out_size,
  output logic                    out_last
);

  localparam int unsigned DATA_W = LANES * COEF_W;
  localparam int unsigned BEATS  = BLOCK_LEN / LANES;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned PTR_W  = $clog2(LANES) + 1;
  localparam int unsigned RUN_W  = 6;
  localparam int unsigned T_W    = 7;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] beat_q, beat_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;

  logic              in_ready_q, in_ready_d;
  logic              ov_q, ov_d;
  logic [1:0]        kind_q, kind_d;
  logic [3:0]        srun_q, srun_d;
  logic [COEF_W-1:0] val_q, val_d;
  logic [3:0]        size_q, size_d;
  logic              last_q, last_d;

  logic [COEF_W-1:0] lane [LANES];
  logic              nz_found;
  logic [PTR_W-1:0]  nz_pos;
  logic [COEF_W-1:0] sel_val;
  logic [COEF_W-1:0] cat_val;
  logic [3:0]        cat_size;
  logic              dc_case;
  logic              is_last;
  logic              out_free;
  logic              pos_end;
  logic [T_W-1:0]    t_run;
  logic [T_W-1:0]    run_add;

  // Split the held beat into lanes; lane 0 sits in the most significant slot
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      lane[i] = beat_q[(int'(LANES) - i) * int'(COEF_W) - 1 -: COEF_W];
    end
  end

  // First nonzero lane at or above the scan pointer
  always_comb begin
    nz_found = 1'b0;
    nz_pos   = '0;
    sel_val  = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if ((lane[i] != '0) && (PTR_W'(i) >= ptr_q)) begin
        nz_found = 1'b1;
        nz_pos   = PTR_W'(i);
        sel_val  = lane[i];
      end
    end
  end

  assign dc_case  = (DC_FIRST != 0) && (cnt_q == '0) && (ptr_q == '0);
  assign is_last  = (cnt_q == BEAT_W'(BEATS - 1));
  assign out_free = !ov_q || out_ready;
  assign pos_end  = (nz_pos == PTR_W'(LANES - 1));
  assign t_run    = T_W'(run_q) + T_W'(nz_pos) - T_W'(ptr_q);
  assign run_add  = T_W'(run_q) + T_W'(LANES) - T_W'(ptr_q);
  assign cat_val  = dc_case ? lane[0] : sel_val;

  rle_size_cat #(.COEF_W(COEF_W)) u_size_cat (
    .value_i (cat_val),
    .size_o  (cat_size)
  );

  // Next-state and next-output logic: one scan action per free output slot
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    ov_d    = ov_q && !out_ready;
    kind_d  = kind_q;
    srun_d  = srun_q;
    val_d   = val_q;
    size_d  = size_q;
    last_d  = last_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          beat_d  = in_data;
          ptr_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (out_free) begin
          if (dc_case) begin
            ov_d   = 1'b1;
            kind_d = KIND_DC;
            srun_d = '0;
            val_d  = lane[0];
            size_d = cat_size;
            last_d = 1'b0;
            ptr_d  = PTR_W'(1);
            if (LANES == 1) begin
              state_d = ST_LOAD;
              cnt_d   = cnt_q + BEAT_W'(1);
            end
          end else if (nz_found) begin
            if (t_run >= T_W'(ZRL_SPAN)) begin
              // Run too long for one AC: emit 16 zeros and re-examine the same lane
              ov_d   = 1'b1;
              kind_d = KIND_ZRL;
              srun_d = 4'(ZRL_RUN);
              val_d  = '0;
              size_d = '0;
              last_d = 1'b0;
              run_d  = RUN_W'(t_run - T_W'(ZRL_SPAN));
              ptr_d  = nz_pos;
            end else begin
              ov_d   = 1'b1;
              kind_d = KIND_AC;
              srun_d = 4'(t_run);
              val_d  = sel_val;
              size_d = cat_size;
              last_d = is_last && pos_end;
              run_d  = '0;
              ptr_d  = nz_pos + PTR_W'(1);
              if (pos_end) begin
                state_d = ST_LOAD;
                cnt_d   = is_last ? '0 : cnt_q + BEAT_W'(1);
              end
            end
          end else begin
            // Rest of the beat is zero: fold it into the run
            state_d = ST_LOAD;
            if (is_last) begin
              cnt_d = '0;
              run_d = '0;
              if (run_add != '0) begin
                ov_d   = 1'b1;
                kind_d = KIND_EOB;
                srun_d = '0;
                val_d  = '0;
                size_d = '0;
                last_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + BEAT_W'(1);
              run_d = RUN_W'(run_add);
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    in_ready_d = (state_d == ST_LOAD);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      beat_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      in_ready_q <= 1'b1;
      ov_q       <= 1'b0;
      kind_q     <= '0;
      srun_q     <= '0;
      val_q      <= '0;
      size_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      in_ready_q <= in_ready_d;
      ov_q       <= ov_d;
      kind_q     <= kind_d;
      srun_q     <= srun_d;
      val_q      <= val_d;
      size_q     <= size_d;
      last_q     <= last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = ov_q;
  assign out_kind  = kind_q;
  assign out_run   = srun_q;
  assign out_value = val_q;
  assign out_size  = size_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_rle_symbol_encoder.sv
// Bench for rle_symbol_encoder: directed and random blocks against a stream model.
module tb_rle_symbol_encoder;

  localparam int unsigned COEF_W   = 12;
  localparam int unsigned LANES    = 8;
  localparam int unsigned BEATS    = 64 / LANES;
  localparam int unsigned DC_FIRST = 1;
  localparam int unsigned DW       = LANES * COEF_W;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  run;
    logic [11:0] value;
    logic [3:0]  size;
    logic        last;
  } sym_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_kind;
  logic [3:0]    out_run;
  logic [11:0]   out_value;
  logic [3:0]    out_size;
  logic          out_last;

  sym_t exp_q[$];
  int   blk[64];
  int   compared   = 0;
  int   mismatched = 0;
  bit   discard    = 1'b0;
  bit   stall_en   = 1'b0;

  rle_symbol_encoder #(.COEF_W(COEF_W), .LANES(LANES), .DC_FIRST(DC_FIRST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_run   (out_run),
    .out_value (out_value),
    .out_size  (out_size),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input int v);
    int a;
    int s;
    a = (v < 0) ? -v : v;
    s = 0;
    while (a > 0) begin
      s++;
      a = a >> 1;
    end
    return s;
  endfunction

  function automatic sym_t mk(input logic [1:0] kind, input int run, input int val);
    sym_t s;
    s.kind  = kind;
    s.run   = 4'(run);
    s.value = 12'(val);
    s.size  = 4'(size_of(val));
    s.last  = 1'b0;
    return s;
  endfunction

  // Reference JPEG run-length coding of the whole block at stream level
  task automatic model();
    sym_t bq[$];
    int   run;
    int   start;
    run   = 0;
    start = 0;
    if (DC_FIRST != 0) begin
      bq.push_back(mk(2'd0, 0, blk[0]));
      start = 1;
    end
    for (int k = start; k < 64; k++) begin
      if (blk[k] == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          bq.push_back(mk(2'd2, 15, 0));
          run -= 16;
        end
        bq.push_back(mk(2'd1, run, blk[k]));
        run = 0;
      end
    end
    if (run > 0) bq.push_back(mk(2'd3, 0, 0));
    bq[bq.size()-1].last = 1'b1;
    foreach (bq[i]) exp_q.push_back(bq[i]);
  endtask

  function automatic logic [DW-1:0] pack(input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      d[(int'(LANES) - i) * int'(COEF_W) - 1 -: COEF_W] = COEF_W'(blk[b * int'(LANES) + i]);
    end
    return d;
  endfunction

  task automatic clear_blk();
    foreach (blk[k]) blk[k] = 0;
  endtask

  task automatic rand_blk(input int dens);
    logic signed [11:0] r;
    for (int k = 0; k < 64; k++) begin
      if (int'($urandom_range(0, 99)) < dens) begin
        if ($urandom_range(0, 1) == 0) begin
          r = 12'($urandom);
          blk[k] = (r == 0) ? 1 : int'(r);
        end else begin
          blk[k] = int'($urandom_range(1, 7));
          if ($urandom_range(0, 1) == 0) blk[k] = -blk[k];
        end
      end else begin
        blk[k] = 0;
      end
    end
  endtask

  // Drive one beat; called and returns at a falling edge
  task automatic send_beat(input int b);
    int guard;
    if (stall_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_data  = pack(b);
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("beat_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_scan", 32'(in_ready), 32'd0);
  endtask

  task automatic send_block(input bit with_model, input int nbeats);
    if (with_model) model();
    for (int b = 0; b < nbeats; b++) send_beat(b);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Output side: random back-pressure, hold check under stall, scoreboard pop
  initial begin
    sym_t obs;
    sym_t held_sym;
    sym_t e;
    bit   held;
    bit   rdy;
    held      = 1'b0;
    held_sym  = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      obs = {out_kind, out_run, out_value, out_size, out_last};
      if (rst) begin
        held      = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (held) check("stall_hold", 32'({out_valid, obs}), 32'({1'b1, held_sym}));
        rdy       = discard ? 1'b1 : (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
        out_ready = rdy;
        held      = 1'b0;
        if (out_valid) begin
          if (!rdy) begin
            held     = 1'b1;
            held_sym = obs;
          end else if (!discard) begin
            if (exp_q.size() == 0) begin
              compared++;
              mismatched++;
              $error("FAIL unexpected_symbol observed=%0h expected=none", obs);
            end else begin
              e = exp_q.pop_front();
              check("symbol", 32'(obs), 32'(e));
            end
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_fields",    32'({out_kind, out_run, out_value, out_size, out_last}), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // DC only: DC(0,5,s3) then EOB
    clear_blk(); blk[0] = 5;
    send_block(1'b1, BEATS);
    // Long run ending on coefficient 63: three ZRLs, final AC flagged last, no EOB
    clear_blk(); blk[1] = -3; blk[63] = 1;
    send_block(1'b1, BEATS);
    // One ZRL then AC(4,100)
    clear_blk(); blk[21] = 100;
    send_block(1'b1, BEATS);
    // Trailing zeros produce EOB only
    clear_blk(); blk[5] = 7;
    send_block(1'b1, BEATS);
    // Most negative coefficient: size 12 both as DC and AC
    clear_blk(); blk[0] = -2048; blk[10] = -2048; blk[47] = 2047;
    send_block(1'b1, BEATS);
    // All-zero block: DC(0) then EOB
    clear_blk();
    send_block(1'b1, BEATS);
    // Run of exactly 16 and coefficient 63 set
    clear_blk(); blk[17] = -1; blk[63] = -5;
    send_block(1'b1, BEATS);
    wait_drain();

    // Random blocks with input and output stalls
    stall_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rand_blk((n % 4 == 0) ? 3 : ((n % 4 == 1) ? 15 : ((n % 4 == 2) ? 50 : 90)));
      send_block(1'b1, BEATS);
    end
    wait_drain();

    // Reset mid-block discards the partial block
    stall_en = 1'b0;
    discard  = 1'b1;
    rand_blk(40);
    send_block(1'b0, 3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_fields",    32'({out_kind, out_run, out_value, out_size, out_last}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    discard = 1'b0;
    clear_blk(); blk[0] = -9; blk[2] = 4; blk[30] = 1;
    send_block(1'b1, BEATS);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
